egr_tqu_mq: RTL and testbench

Parametrised multi-queue Tag Queuing Unit for the egress partition. It stores packet tags from the Packet Read Controller in NUM_Q independent circular FIFOs, one per egress port/TC queue. It returns the head tag to the Transmit Controller Unit on request with one-cycle latency. Compared with the single-queue TQU, it adds a per-queue flush, per-queue occupancy and empty status, and sticky overflow/underflow error reporting.

---
 rtl/egr_tqu_mq.sv | 227 ++++++++++++++++++++++
 tb/tb_egr_tqu_mq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/egr_tqu_mq.sv
// -----------------------------------------------------------------------------
// egr_tqu_mq
//
// Multi-queue Tag Queuing Unit for the egress partition. Packet tags from the
// Packet Read Controller are stored in NUM_Q independent circular FIFOs (one
// per egress port/TC queue). The Transmit Controller Unit pops the head of a
// chosen queue and receives the tag one cycle later.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   enq_valid/qid/tag : enqueue request from the PRC
//   enq_ready         : combinational, !full of the queue addressed by enq_qid
//   deq_req/qid       : dequeue request from the TCU
//   deq_rsp_valid/hit/tag : registered response, one cycle after deq_req
//   flush             : per-queue synchronous flush (wins over enq/deq)
//   q_cnt, q_empty    : registered per-queue occupancy / empty flags
//   err_ovf, err_udf  : sticky per-queue overflow / underflow flags
//   err_clr           : clears both sticky error vectors
//
// Handshake: an enqueue transfers on a rising edge where enq_valid and
// enq_ready are both high (and the target queue is not being flushed).
// enq_ready is derived from registered occupancy and enq_qid only, so it never
// depends on enq_valid or deq_req. A producer seeing enq_ready low must hold
// the tag; asserting enq_valid anyway drops the tag and sets err_ovf. The
// dequeue side has no back-pressure: every deq_req gets exactly one response
// with deq_rsp_valid high in the following cycle, hit telling whether a tag
// was actually popped.
// -----------------------------------------------------------------------------
module egr_tqu_mq #(
    parameter int NUM_Q = 4,
    parameter int DEPTH = 8,
    parameter int TAG_W = 16,
    localparam int QID_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enq_valid,
    input  logic [QID_W-1:0]       enq_qid,
    input  logic [TAG_W-1:0]       enq_tag,
    output logic                   enq_ready,
    input  logic                   deq_req,
    input  logic [QID_W-1:0]       deq_qid,
    output logic                   deq_rsp_valid,
    output logic                   deq_rsp_hit,
    output logic [TAG_W-1:0]       deq_rsp_tag,
    input  logic [NUM_Q-1:0]       flush,
    output logic [NUM_Q*CNT_W-1:0] q_cnt,
    output logic [NUM_Q-1:0]       q_empty,
    output logic [NUM_Q-1:0]       err_ovf,
    output logic [NUM_Q-1:0]       err_udf,
    input  logic                   err_clr
);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    // Tag storage; deliberately not reset, pointers/counts define validity.
    logic [TAG_W-1:0] mem_q [NUM_Q][DEPTH];

    ptr_t             wr_ptr_q [NUM_Q];
    ptr_t             wr_ptr_d [NUM_Q];
    ptr_t             rd_ptr_q [NUM_Q];
    ptr_t             rd_ptr_d [NUM_Q];
    cnt_t             cnt_q    [NUM_Q];
    cnt_t             cnt_d    [NUM_Q];

    logic [NUM_Q-1:0] empty_q;
    logic [NUM_Q-1:0] empty_d;
    logic [NUM_Q-1:0] ovf_q;
    logic [NUM_Q-1:0] ovf_d;
    logic [NUM_Q-1:0] udf_q;
    logic [NUM_Q-1:0] udf_d;

    logic             rsp_valid_q;
    logic             rsp_valid_d;
    logic             rsp_hit_q;
    logic             rsp_hit_d;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [TAG_W-1:0] rsp_tag_d;

    // One-hot decodes of the two queue ids, plus per-queue status.
    logic [NUM_Q-1:0] enq_hot;
    logic [NUM_Q-1:0] deq_hot;
    logic [NUM_Q-1:0] full;
    logic [NUM_Q-1:0] enq_ok;
    logic [NUM_Q-1:0] deq_ok;
    logic [NUM_Q-1:0] ovf_set;
    logic [NUM_Q-1:0] udf_set;

    // -------------------------------------------------------------------------
    // Decode and per-queue accept decisions. Everything here looks at
    // registered state only, so a dequeue freeing a slot in a full queue does
    // not open enq_ready in the same cycle, and an enqueue into an empty
    // queue is never bypassed to a same-cycle dequeue.
    // -------------------------------------------------------------------------
    always_comb begin
        enq_hot = '0;
        deq_hot = '0;
        full    = '0;
        enq_ok  = '0;
        deq_ok  = '0;
        ovf_set = '0;
        udf_set = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            enq_hot[q] = (enq_qid == QID_W'(q));
            deq_hot[q] = (deq_qid == QID_W'(q));
            full[q]    = (cnt_q[q] == CNT_FULL);
            // Flush suppresses both the operation and its error report.
            enq_ok[q]  = enq_valid & enq_hot[q] & ~full[q] & ~flush[q];
            deq_ok[q]  = deq_req & deq_hot[q] & ~empty_q[q] & ~flush[q];
            ovf_set[q] = enq_valid & enq_hot[q] & full[q] & ~flush[q];
            udf_set[q] = deq_req & deq_hot[q] & empty_q[q] & ~flush[q];
        end
    end

    // An id beyond NUM_Q-1 matches no queue: it reports ready and the tag is
    // discarded, and a dequeue of it answers with hit=0.
    assign enq_ready = ~|(enq_hot & full);

    // -------------------------------------------------------------------------
    // Next-state for pointers, counts, empty flags and sticky errors.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int q = 0; q < NUM_Q; q++) begin
            wr_ptr_d[q] = wr_ptr_q[q];
            rd_ptr_d[q] = rd_ptr_q[q];
            cnt_d[q]    = cnt_q[q];
        end
        empty_d = empty_q;
        for (int q = 0; q < NUM_Q; q++) begin
            if (flush[q]) begin
                wr_ptr_d[q] = '0;
                rd_ptr_d[q] = '0;
                cnt_d[q]    = '0;
            end else begin
                // Pointers wrap naturally because DEPTH is a power of two.
                if (enq_ok[q]) begin
                    wr_ptr_d[q] = wr_ptr_q[q] + ptr_t'(1);
                end
                if (deq_ok[q]) begin
                    rd_ptr_d[q] = rd_ptr_q[q] + ptr_t'(1);
                end
                case ({enq_ok[q], deq_ok[q]})
                    2'b10:   cnt_d[q] = cnt_q[q] + cnt_t'(1);
                    2'b01:   cnt_d[q] = cnt_q[q] - cnt_t'(1);
                    default: cnt_d[q] = cnt_q[q];
                endcase
            end
            empty_d[q] = (cnt_d[q] == '0);
        end
        // A new error event outranks a same-cycle clear.
        ovf_d = (err_clr ? '0 : ovf_q) | ovf_set;
        udf_d = (err_clr ? '0 : udf_q) | udf_set;
    end

    // -------------------------------------------------------------------------
    // Dequeue response. At most one bit of deq_ok is set, so an AND-OR mux of
    // the per-queue heads yields the popped tag, and zero on a miss.
    // -------------------------------------------------------------------------
    always_comb begin
        rsp_valid_d = deq_req;
        rsp_hit_d   = |deq_ok;
        rsp_tag_d   = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            rsp_tag_d = rsp_tag_d | ({TAG_W{deq_ok[q]}} & mem_q[q][rd_ptr_q[q]]);
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < NUM_Q; q++) begin
                wr_ptr_q[q] <= '0;
                rd_ptr_q[q] <= '0;
                cnt_q[q]    <= '0;
            end
            empty_q     <= '1;
            ovf_q       <= '0;
            udf_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_tag_q   <= '0;
        end else begin
            for (int q = 0; q < NUM_Q; q++) begin
                wr_ptr_q[q] <= wr_ptr_d[q];
                rd_ptr_q[q] <= rd_ptr_d[q];
                cnt_q[q]    <= cnt_d[q];
            end
            empty_q     <= empty_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    // Storage write port: one write per queue per cycle at most.
    always_ff @(posedge clk) begin
        for (int q = 0; q < NUM_Q; q++) begin
            if (enq_ok[q]) begin
                mem_q[q][wr_ptr_q[q]] <= enq_tag;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_Q; g++) begin : g_cnt_pack
        assign q_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign q_empty       = empty_q;
    assign err_ovf       = ovf_q;
    assign err_udf       = udf_q;
    assign deq_rsp_valid = rsp_valid_q;
    assign deq_rsp_hit   = rsp_hit_q;
    assign deq_rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_egr_tqu_mq.sv
// -----------------------------------------------------------------------------
// tb_egr_tqu_mq
//
// Bench for egr_tqu_mq (NUM_Q=4, DEPTH=8, TAG_W=16). A reference model made of
// one SystemVerilog queue per hardware queue predicts every response, count,
// empty flag, error flag and enq_ready; a compare process checks the DUT
// against it after every rising edge. Directed scenarios add literal
// expectations, then a randomized phase and a mid-operation reset follow.
// -----------------------------------------------------------------------------
module tb_egr_tqu_mq;
  localparam int NQ = 4;
  localparam int DP = 8;
  localparam int TW = 16;
  localparam int CW = 4;
  localparam int QW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             enq_valid;
  logic [QW-1:0]    enq_qid;
  logic [TW-1:0]    enq_tag;
  logic             enq_ready;
  logic             deq_req;
  logic [QW-1:0]    deq_qid;
  logic             deq_rsp_valid;
  logic             deq_rsp_hit;
  logic [TW-1:0]    deq_rsp_tag;
  logic [NQ-1:0]    flush;
  logic [NQ*CW-1:0] q_cnt;
  logic [NQ-1:0]    q_empty;
  logic [NQ-1:0]    err_ovf;
  logic [NQ-1:0]    err_udf;
  logic             err_clr;

  egr_tqu_mq #(.NUM_Q(NQ), .DEPTH(DP), .TAG_W(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enq_valid     (enq_valid),
    .enq_qid       (enq_qid),
    .enq_tag       (enq_tag),
    .enq_ready     (enq_ready),
    .deq_req       (deq_req),
    .deq_qid       (deq_qid),
    .deq_rsp_valid (deq_rsp_valid),
    .deq_rsp_hit   (deq_rsp_hit),
    .deq_rsp_tag   (deq_rsp_tag),
    .flush         (flush),
    .q_cnt         (q_cnt),
    .q_empty       (q_empty),
    .err_ovf       (err_ovf),
    .err_udf       (err_udf),
    .err_clr       (err_clr)
  );

  // ---------------- scoreboard / model ----------------
  int chk_total = 0;
  int chk_pass  = 0;

  logic [TW-1:0] mq [NQ][$];   // model contents of each queue, head first
  logic [TW:0]   exp_q[$];     // expected {hit, tag} responses
  logic [NQ-1:0] m_ovf;
  logic [NQ-1:0] m_udf;
  bit            pend_deq = 1'b0;
  bit            chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_total++;
    if (act === exp) chk_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) mq[i].delete();
    exp_q.delete();
    m_ovf    = '0;
    m_udf    = '0;
    pend_deq = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Presents one cycle of stimulus at the falling edge, advances the model to
  // the state expected after the next rising edge, then idles the strobes.
  task automatic cyc(input bit ev, input int eq, input logic [TW-1:0] et,
                     input bit dr, input int dq, input logic [NQ-1:0] fl, input bit ec);
    logic [NQ-1:0] ovf_set;
    logic [NQ-1:0] udf_set;
    bit            full_pre;
    @(negedge clk);
    enq_valid = ev;
    enq_qid   = QW'(eq);
    enq_tag   = et;
    deq_req   = dr;
    deq_qid   = QW'(dq);
    flush     = fl;
    err_clr   = ec;
    ovf_set   = '0;
    udf_set   = '0;
    full_pre  = (mq[eq].size() == DP);
    if (dr) begin
      if (fl[dq]) exp_q.push_back('0);
      else if (mq[dq].size() == 0) begin
        exp_q.push_back('0);
        udf_set[dq] = 1'b1;
      end else exp_q.push_back({1'b1, mq[dq].pop_front()});
      pend_deq = 1'b1;
    end
    if (ev && !fl[eq]) begin
      if (full_pre) ovf_set[eq] = 1'b1;
      else mq[eq].push_back(et);
    end
    for (int i = 0; i < NQ; i++) if (fl[i]) mq[i].delete();
    m_ovf = (ec ? '0 : m_ovf) | ovf_set;
    m_udf = (ec ? '0 : m_udf) | udf_set;
    @(posedge clk);
    #2;
    enq_valid = 1'b0;
    deq_req   = 1'b0;
    flush     = '0;
    err_clr   = 1'b0;
  endtask

  task automatic rand_cyc();
    logic [NQ-1:0] fl;
    fl = ($urandom_range(0, 39) == 0) ? NQ'($urandom_range(1, 15)) : '0;
    cyc($urandom_range(0, 99) < 60, $urandom_range(0, NQ-1), TW'($urandom),
        $urandom_range(0, 99) < 45, $urandom_range(0, NQ-1), fl,
        $urandom_range(0, 15) == 0);
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    logic [TW:0]   e;
    logic [NQ-1:0] exp_empty;
    #1;
    if (chk_en) begin
      if (pend_deq) begin
        check("rsp_valid", 32'(deq_rsp_valid), 32'd1);
        if (exp_q.size() == 0) begin
          check("rsp_expected_present", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("rsp_hit", 32'(deq_rsp_hit), 32'(e[TW]));
          check("rsp_tag", 32'(deq_rsp_tag), 32'(e[TW-1:0]));
        end
        pend_deq = 1'b0;
      end else begin
        check("rsp_valid_idle", 32'(deq_rsp_valid), 32'd0);
      end
      exp_empty = '0;
      for (int i = 0; i < NQ; i++) begin
        check($sformatf("q_cnt[%0d]", i), 32'(q_cnt[i*CW +: CW]), 32'(mq[i].size()));
        exp_empty[i] = (mq[i].size() == 0);
      end
      check("q_empty", 32'(q_empty), 32'(exp_empty));
      check("err_ovf", 32'(err_ovf), 32'(m_ovf));
      check("err_udf", 32'(err_udf), 32'(m_udf));
      check("enq_ready", 32'(enq_ready), 32'(mq[enq_qid].size() != DP));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    enq_valid = 1'b0;
    enq_qid   = '0;
    enq_tag   = '0;
    deq_req   = 1'b0;
    deq_qid   = '0;
    flush     = '0;
    err_clr   = 1'b0;
    model_reset();

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    check("rst_q_empty", 32'(q_empty), 32'hF);
    check("rst_q_cnt", 32'(q_cnt), 32'd0);
    check("rst_enq_ready", 32'(enq_ready), 32'd1);
    check("rst_rsp_valid", 32'(deq_rsp_valid), 32'd0);
    check("rst_rsp_hit", 32'(deq_rsp_hit), 32'd0);
    check("rst_rsp_tag", 32'(deq_rsp_tag), 32'd0);
    check("rst_err_ovf", 32'(err_ovf), 32'd0);
    check("rst_err_udf", 32'(err_udf), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Fill q2, force an overflow, drain in order.
    for (int i = 0; i < 8; i++) cyc(1, 2, TW'(16'h0100 + i), 0, 0, '0, 0);
    check("fill_q2_cnt", 32'(q_cnt[2*CW +: CW]), 32'd8);
    check("fill_q2_ready", 32'(enq_ready), 32'd0);
    cyc(1, 2, 16'h0108, 0, 0, '0, 0);
    check("ovf_q2", 32'(err_ovf), 32'h4);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 2, '0, 1, 2, '0, 0);
      check("drain_q2_hit", 32'(deq_rsp_hit), 32'd1);
      check("drain_q2_tag", 32'(deq_rsp_tag), 32'h0100 + 32'(i));
    end
    cyc(0, 0, '0, 0, 0, '0, 1);
    check("clr_ovf", 32'(err_ovf), 32'd0);

    // Wrap-around on q1 with occupancy held at 3.
    for (int i = 0; i < 3; i++) cyc(1, 1, TW'(16'h1000 + i), 0, 0, '0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, TW'(16'h1003 + i), 1, 1, '0, 0);
      check("wrap_q1_tag", 32'(deq_rsp_tag), 32'h1000 + 32'(i));
    end
    check("wrap_q1_cnt", 32'(q_cnt[1*CW +: CW]), 32'd3);

    // Full q0 with simultaneous enq+deq; empty q3 with simultaneous enq+deq.
    for (int i = 0; i < 8; i++) cyc(1, 0, TW'(16'h2000 + i), 0, 0, '0, 0);
    cyc(1, 0, 16'hAAAA, 1, 0, '0, 0);
    check("full_deq_hit", 32'(deq_rsp_hit), 32'd1);
    check("full_deq_tag", 32'(deq_rsp_tag), 32'h2000);
    check("full_deq_cnt", 32'(q_cnt[0*CW +: CW]), 32'd7);
    check("full_enq_ovf", 32'(err_ovf), 32'h1);
    cyc(1, 3, 16'hBBBB, 1, 3, '0, 0);
    check("empty_deq_hit", 32'(deq_rsp_hit), 32'd0);
    check("empty_deq_tag", 32'(deq_rsp_tag), 32'd0);
    check("empty_deq_udf", 32'(err_udf), 32'h8);
    check("empty_enq_cnt", 32'(q_cnt[3*CW +: CW]), 32'd1);

    // Flush q1 holding 5 tags with concurrent enq and deq.
    cyc(0, 0, '0, 0, 0, '0, 1);
    cyc(1, 1, 16'h1100, 0, 0, '0, 0);
    cyc(1, 1, 16'h1101, 0, 0, '0, 0);
    check("pre_flush_q1_cnt", 32'(q_cnt[1*CW +: CW]), 32'd5);
    cyc(1, 1, 16'hCCCC, 1, 1, 4'b0010, 0);
    check("flush_hit", 32'(deq_rsp_hit), 32'd0);
    check("flush_q1_cnt", 32'(q_cnt[1*CW +: CW]), 32'd0);
    check("flush_no_ovf", 32'(err_ovf), 32'd0);
    check("flush_no_udf", 32'(err_udf), 32'd0);
    check("flush_q0_cnt", 32'(q_cnt[0*CW +: CW]), 32'd7);
    check("flush_q2_cnt", 32'(q_cnt[2*CW +: CW]), 32'd0);

    // Interleaved dequeues across all queues, then clear the sticky bits.
    for (int i = 0; i < 12; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, NQ-1), TW'($urandom), 1, i % NQ, '0, 0);
      if (i == 0) check("interleave_q0_head", 32'(deq_rsp_tag), 32'h2001);
    end
    cyc(0, 0, '0, 0, 0, '0, 1);
    check("clr_all_ovf", 32'(err_ovf), 32'd0);
    check("clr_all_udf", 32'(err_udf), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) rand_cyc();

    // Reset mid-operation with a response pending.
    for (int i = 0; i < 4; i++) cyc(1, 0, TW'(16'h3000 + i), 0, 0, '0, 0);
    @(negedge clk);
    chk_en  = 1'b0;
    deq_req = 1'b1;
    deq_qid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_q_cnt", 32'(q_cnt), 32'd0);
    check("mid_rst_q_empty", 32'(q_empty), 32'hF);
    check("mid_rst_err", 32'({err_ovf, err_udf}), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_rsp_lost", 32'(deq_rsp_valid), 32'd0);
    deq_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 300; i++) rand_cyc();

    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
